// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared constants and FSM state encoding for the run splitter
package sort_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int SENTINEL   = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_TERM   = 3'd2,
    ST_PAD    = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/split_out_reg.sv
// rtl/split_out_reg.sv - one-entry holding register steering writes to merger FIFO 1 or FIFO 2
module split_out_reg
  import sort_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_load_sel,
  input  logic              i_fifo_1_full,
  input  logic              i_fifo_2_full,
  output logic              o_can_load,
  output logic              o_hold_vld,
  output logic [DATA_W-1:0] o_fifo_1_data,
  output logic              o_fifo_1_write,
  output logic [DATA_W-1:0] o_fifo_2_data,
  output logic              o_fifo_2_write
);

  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_sel_q, hold_sel_d;
  logic              drain;

  // hold_sel 0 targets FIFO 1, 1 targets FIFO 2
  always_comb begin
    o_fifo_1_write = hold_vld_q & ~hold_sel_q & ~i_fifo_1_full;
    o_fifo_2_write = hold_vld_q &  hold_sel_q & ~i_fifo_2_full;
    drain          = o_fifo_1_write | o_fifo_2_write;
    o_can_load     = ~hold_vld_q | drain;
    hold_vld_d     = hold_vld_q & ~drain;
    hold_data_d    = hold_data_q;
    hold_sel_d     = hold_sel_q;
    if (i_load) begin
      hold_vld_d  = 1'b1;
      hold_data_d = i_load_data;
      hold_sel_d  = i_load_sel;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      hold_sel_q  <= 1'b0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      hold_sel_q  <= hold_sel_d;
    end
  end

  assign o_hold_vld    = hold_vld_q;
  assign o_fifo_1_data = hold_data_q;
  assign o_fifo_2_data = hold_data_q;

endmodule

// File: rtl/run_splitter.sv
// rtl/run_splitter.sv - cuts a record stream into sentinel-terminated runs alternating FIFO 1/FIFO 2
// Optional order checking is enabled by defining RUN_SPLITTER_ORDER_CHECK_EN.
module run_splitter
  import sort_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RUN_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_empty,
  input  logic              i_data_last,
  output logic              o_data_read,
  output logic [DATA_W-1:0] o_fifo_1_data,
  output logic              o_fifo_1_write,
  input  logic              i_fifo_1_full,
  output logic [DATA_W-1:0] o_fifo_2_data,
  output logic              o_fifo_2_write,
  input  logic              i_fifo_2_full,
  output logic [CNT_W-1:0]  o_run_count,
  output logic              o_done,
  output logic              o_err_zero,
  output logic              o_err_order
);

  localparam logic [CNT_W-1:0]  REC_LAST = CNT_W'(RUN_LEN - 1);
  localparam logic [DATA_W-1:0] SENT     = DATA_W'(SENTINEL);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rec_q, rec_d, run_cnt_q, run_cnt_d, run_cnt_inc;
  logic              sel_q, sel_d, last_q, last_d, done_q, done_d, err_zero_q, err_zero_d;
  logic              load, load_sel, can_load, hold_vld, pop;
  logic [DATA_W-1:0] load_data;
`ifdef RUN_SPLITTER_ORDER_CHECK_EN
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d, err_order_q, err_order_d;
`endif

  assign pop         = (state_q == ST_STREAM) & ~i_data_empty & can_load;
  assign run_cnt_inc = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rec_d      = rec_q;
    run_cnt_d  = run_cnt_q;
    sel_d      = sel_q;
    last_d     = last_q;
    done_d     = done_q;
    err_zero_d = err_zero_q;
    load       = 1'b0;
    load_data  = SENT;
    load_sel   = sel_q;
`ifdef RUN_SPLITTER_ORDER_CHECK_EN
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    err_order_d = err_order_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d    = ST_STREAM;
          rec_d      = '0;
          run_cnt_d  = '0;
          sel_d      = 1'b0;
          last_d     = 1'b0;
          done_d     = 1'b0;
          err_zero_d = 1'b0;
`ifdef RUN_SPLITTER_ORDER_CHECK_EN
          prev_vld_d  = 1'b0;
          err_order_d = 1'b0;
`endif
        end
      end
      ST_STREAM: begin
        if (pop) begin
          // 0 is reserved for the merger's end-of-run marker, so a stray 0 becomes 1
          load       = 1'b1;
          load_data  = (i_data == SENT) ? DATA_W'(1) : i_data;
          err_zero_d = err_zero_q | (i_data == SENT);
          rec_d      = (rec_q == '1) ? rec_q : rec_q + 1'b1;
          last_d     = i_data_last;
`ifdef RUN_SPLITTER_ORDER_CHECK_EN
          if (prev_vld_q && (load_data < prev_q)) err_order_d = 1'b1;
          prev_d     = load_data;
          prev_vld_d = 1'b1;
`endif
          if ((rec_q == REC_LAST) || i_data_last) state_d = ST_TERM;
        end
      end
      ST_TERM: begin
        if (can_load) begin
          load      = 1'b1;
          run_cnt_d = run_cnt_inc;
          sel_d     = ~sel_q;
          rec_d     = '0;
`ifdef RUN_SPLITTER_ORDER_CHECK_EN
          prev_vld_d = 1'b0;
`endif
          if (!last_q)            state_d = ST_STREAM;
          else if (run_cnt_inc[0]) state_d = ST_PAD;
          else                    state_d = ST_DRAIN;
        end
      end
      ST_PAD: begin
        if (can_load) begin
          load      = 1'b1;
          load_sel  = 1'b1;
          run_cnt_d = run_cnt_inc;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!hold_vld) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      rec_q      <= '0;
      run_cnt_q  <= '0;
      sel_q      <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_zero_q <= 1'b0;
`ifdef RUN_SPLITTER_ORDER_CHECK_EN
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      err_order_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rec_q      <= rec_d;
      run_cnt_q  <= run_cnt_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      done_q     <= done_d;
      err_zero_q <= err_zero_d;
`ifdef RUN_SPLITTER_ORDER_CHECK_EN
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      err_order_q <= err_order_d;
`endif
    end
  end

  split_out_reg #(.DATA_W(DATA_W)) u_out (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_load         (load),
    .i_load_data    (load_data),
    .i_load_sel     (load_sel),
    .i_fifo_1_full  (i_fifo_1_full),
    .i_fifo_2_full  (i_fifo_2_full),
    .o_can_load     (can_load),
    .o_hold_vld     (hold_vld),
    .o_fifo_1_data  (o_fifo_1_data),
    .o_fifo_1_write (o_fifo_1_write),
    .o_fifo_2_data  (o_fifo_2_data),
    .o_fifo_2_write (o_fifo_2_write)
  );

  assign o_data_read = pop;
  assign o_run_count = run_cnt_q;
  assign o_done      = done_q;
  assign o_err_zero  = err_zero_q;
`ifdef RUN_SPLITTER_ORDER_CHECK_EN
  assign o_err_order = err_order_q;
`else
  assign o_err_order = 1'b0;
`endif

endmodule

// File: tb/tb_run_splitter.sv
// tb/tb_run_splitter.sv - randomized self-checking bench for run_splitter against a run-list model
module tb_run_splitter;
  localparam int DATA_W = 32, RUN_LEN = 4, CNT_W = 16;
  typedef logic [DATA_W-1:0] word_q_t[$];

  logic i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0;
  logic [DATA_W-1:0] i_data = '0;
  logic i_data_empty = 1'b1, i_data_last = 1'b0, i_fifo_1_full = 1'b0, i_fifo_2_full = 1'b0;
  logic o_data_read, o_fifo_1_write, o_fifo_2_write, o_done, o_err_zero, o_err_order;
  logic [DATA_W-1:0] o_fifo_1_data, o_fifo_2_data;
  logic [CNT_W-1:0] o_run_count;

  run_splitter #(.DATA_W(DATA_W), .RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_data(i_data),
    .i_data_empty(i_data_empty), .i_data_last(i_data_last), .o_data_read(o_data_read),
    .o_fifo_1_data(o_fifo_1_data), .o_fifo_1_write(o_fifo_1_write), .i_fifo_1_full(i_fifo_1_full),
    .o_fifo_2_data(o_fifo_2_data), .o_fifo_2_write(o_fifo_2_write), .i_fifo_2_full(i_fifo_2_full),
    .o_run_count(o_run_count), .o_done(o_done), .o_err_zero(o_err_zero), .o_err_order(o_err_order)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0, n_fail = 0;
  word_q_t stim, src_q, got1, got2, exp1, exp2;
  int exp_runs, viol, first_read, first_w1, win_reads;
  logic exp_zero, exp_order, timed_out;

  function automatic int first_diff(input word_q_t a, input word_q_t b);
    if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
    foreach (a[i]) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  // Model: slice the record list into RUN_LEN chunks (cut early at the last record),
  // alternate chunks between the FIFOs, close each with 0, pad FIFO 2 to an even run count.
  task automatic model_build();
    int pos = 0, run = 0;
    logic [DATA_W-1:0] v, prevv;
    exp1.delete(); exp2.delete(); exp_zero = 0; exp_order = 0; prevv = '0;
    while (pos < stim.size()) begin
      int n = (stim.size() - pos < RUN_LEN) ? stim.size() - pos : RUN_LEN;
      for (int k = 0; k < n; k++) begin
        v = stim[pos+k];
        if (v == 0) begin exp_zero = 1; v = 1; end
`ifdef RUN_SPLITTER_ORDER_CHECK_EN
        if (k > 0 && v < prevv) exp_order = 1;
`endif
        prevv = v;
        if (run % 2 == 0) exp1.push_back(v); else exp2.push_back(v);
      end
      if (run % 2 == 0) exp1.push_back('0); else exp2.push_back('0);
      run++; pos += n;
    end
    if (run % 2 == 1) begin exp2.push_back('0); run++; end
    exp_runs = run;
  endtask

  // mode 0: FIFOs never full; 1: FIFO 1 full for 10 cycles after its first write;
  // 2: random source gaps and random full on both FIFOs
  task automatic drive_stream(input int mode, input bit mid_start);
    int cyc = 0;
    bit fin = 0;
    model_build();
    src_q = stim; got1.delete(); got2.delete();
    viol = 0; first_read = -1; first_w1 = -1; win_reads = 0; timed_out = 0;
    @(negedge i_clk); i_start = 1'b1; i_data_empty = 1'b1; i_fifo_1_full = 0; i_fifo_2_full = 0;
    while (!fin && cyc < 2000) begin
      @(negedge i_clk);
      cyc++;
      i_start = mid_start && (cyc == 3);
      i_data_empty = (src_q.size() == 0) || (mode == 2 && $urandom_range(0, 3) == 0);
      i_data = (src_q.size() != 0) ? src_q[0] : DATA_W'($urandom);
      i_data_last = (src_q.size() == 1);
      i_fifo_1_full = (mode == 1) ? (first_w1 >= 0 && cyc > first_w1 && cyc <= first_w1 + 10)
                    : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      i_fifo_2_full = (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      #1;
      if (o_data_read) begin
        if (i_data_empty) viol++;
        else begin
          void'(src_q.pop_front());
          if (first_read < 0) first_read = cyc;
          if (i_fifo_1_full) win_reads++;
        end
      end
      if (o_fifo_1_write) begin
        if (i_fifo_1_full) viol++;
        got1.push_back(o_fifo_1_data);
        if (first_w1 < 0) first_w1 = cyc;
      end
      if (o_fifo_2_write) begin
        if (i_fifo_2_full) viol++;
        got2.push_back(o_fifo_2_data);
      end
      if (o_fifo_1_write && o_fifo_2_write) viol++;
      if (o_done) fin = 1;
    end
    timed_out = !fin;
    i_start = 0; i_data_empty = 1; i_fifo_1_full = 0; i_fifo_2_full = 0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({o_data_read, o_fifo_1_write, o_fifo_2_write, o_done, o_err_zero, o_err_order} !== 6'b0 ||
        o_run_count !== '0 || o_fifo_1_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rd=%b w1=%b w2=%b done=%b rc=%0d d=%0h required all 0",
               o_data_read, o_fifo_1_write, o_fifo_2_write, o_done, o_run_count, o_fifo_1_data);
    end
    @(negedge i_clk); i_rst_n = 1'b1;
  endtask

  task automatic test_basic();
    stim = {32'd5, 32'd6, 32'd7, 32'd8, 32'd1, 32'd2, 32'd3, 32'd4};
    drive_stream(0, 1'b1);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL basic_done got timeout required done"); end
    n_tests++; if (first_diff(got1, exp1) != -1) begin n_fail++; $display("FAIL basic_f1 got %p required %p", got1, exp1); end
    n_tests++; if (first_diff(got2, exp2) != -1) begin n_fail++; $display("FAIL basic_f2 got %p required %p", got2, exp2); end
    n_tests++; if (o_run_count !== CNT_W'(2)) begin n_fail++; $display("FAIL basic_runs got %0d required 2", o_run_count); end
    n_tests++; if (first_w1 != first_read + 1) begin n_fail++; $display("FAIL basic_latency got %0d required %0d", first_w1, first_read + 1); end
    n_tests++; if (viol != 0) begin n_fail++; $display("FAIL basic_protocol got %0d violations required 0", viol); end
  endtask

  task automatic test_pad();
    stim = {32'd3, 32'd9};
    drive_stream(0, 1'b0);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL pad_done got timeout required done"); end
    n_tests++; if (first_diff(got1, exp1) != -1) begin n_fail++; $display("FAIL pad_f1 got %p required %p", got1, exp1); end
    n_tests++; if (first_diff(got2, exp2) != -1) begin n_fail++; $display("FAIL pad_f2 got %p required %p", got2, exp2); end
    n_tests++; if (o_run_count !== CNT_W'(2)) begin n_fail++; $display("FAIL pad_runs got %0d required 2", o_run_count); end
    stim = {32'd5, 32'd6, 32'd7, 32'd8};
    drive_stream(0, 1'b0);
    n_tests++; if (first_diff(got1, exp1) != -1 || first_diff(got2, exp2) != -1) begin
      n_fail++; $display("FAIL exact_run_len got f1=%p f2=%p required f1=%p f2=%p", got1, got2, exp1, exp2);
    end
  endtask

  task automatic test_f1_stall();
    stim = {32'd5, 32'd6, 32'd7, 32'd8, 32'd1, 32'd2, 32'd3, 32'd4};
    drive_stream(1, 1'b0);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL stall_done got timeout required done"); end
    n_tests++; if (win_reads != 0) begin n_fail++; $display("FAIL stall_no_pop got %0d pops required 0", win_reads); end
    n_tests++; if (first_diff(got1, exp1) != -1) begin n_fail++; $display("FAIL stall_f1 got %p required %p", got1, exp1); end
    n_tests++; if (first_diff(got2, exp2) != -1) begin n_fail++; $display("FAIL stall_f2 got %p required %p", got2, exp2); end
    n_tests++; if (viol != 0) begin n_fail++; $display("FAIL stall_protocol got %0d violations required 0", viol); end
  endtask

  task automatic test_errors();
    stim = {32'd4, 32'd0, 32'd7};
    drive_stream(0, 1'b0);
    n_tests++; if (first_diff(got1, exp1) != -1) begin n_fail++; $display("FAIL zero_f1 got %p required %p", got1, exp1); end
    n_tests++; if (o_err_zero !== 1'b1) begin n_fail++; $display("FAIL zero_flag got %b required 1", o_err_zero); end
    n_tests++; if (o_err_order !== exp_order) begin n_fail++; $display("FAIL zero_order got %b required %b", o_err_order, exp_order); end
    stim = {32'd2, 32'd1};
    drive_stream(0, 1'b0);
    n_tests++; if (o_err_zero !== 1'b0) begin n_fail++; $display("FAIL order_zero_clear got %b required 0", o_err_zero); end
    n_tests++; if (o_err_order !== exp_order) begin n_fail++; $display("FAIL order_flag got %b required %b", o_err_order, exp_order); end
    n_tests++; if (first_diff(got1, exp1) != -1) begin n_fail++; $display("FAIL order_f1 got %p required %p", got1, exp1); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int len = $urandom_range(1, 13);
      bit sorted = $urandom_range(0, 1);
      logic [DATA_W-1:0] v = DATA_W'($urandom_range(0, 5));
      stim.delete();
      for (int k = 0; k < len; k++) begin
        v = sorted ? v + DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom_range(0, 30));
        stim.push_back(v);
      end
      drive_stream(2, 1'b1);
      n_tests++; if (timed_out) begin n_fail++; $display("FAIL rand%0d_done got timeout required done", it); end
      n_tests++; if (first_diff(got1, exp1) != -1) begin n_fail++; $display("FAIL rand%0d_f1 got %p required %p", it, got1, exp1); end
      n_tests++; if (first_diff(got2, exp2) != -1) begin n_fail++; $display("FAIL rand%0d_f2 got %p required %p", it, got2, exp2); end
      n_tests++; if (o_run_count !== CNT_W'(exp_runs)) begin n_fail++; $display("FAIL rand%0d_runs got %0d required %0d", it, o_run_count, exp_runs); end
      n_tests++; if (o_err_zero !== exp_zero || o_err_order !== exp_order) begin
        n_fail++; $display("FAIL rand%0d_errs got z=%b o=%b required z=%b o=%b", it, o_err_zero, o_err_order, exp_zero, exp_order);
      end
      n_tests++; if (viol != 0) begin n_fail++; $display("FAIL rand%0d_protocol got %0d violations required 0", it, viol); end
    end
  endtask

  task automatic test_async_reset();
    bit saw5 = 0;
    int after = 0, acts = 0;
    src_q = {32'd5, 32'd6, 32'd7, 32'd8};
    @(negedge i_clk); i_start = 1'b1;
    for (int cyc = 0; cyc < 50 && after < 3; cyc++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      i_fifo_1_full = saw5;
      i_data_empty = (src_q.size() == 0);
      i_data = (src_q.size() != 0) ? src_q[0] : '0;
      i_data_last = (src_q.size() == 1);
      #1;
      if (o_data_read && !i_data_empty) void'(src_q.pop_front());
      if (saw5) after++;
      if (o_fifo_1_write && o_fifo_1_data == 5) saw5 = 1;
    end
    n_tests++; if (o_fifo_1_data !== DATA_W'(6) || o_fifo_1_write !== 1'b0) begin
      n_fail++; $display("FAIL arst_setup got d=%0d w=%b required d=6 w=0", o_fifo_1_data, o_fifo_1_write);
    end
    i_rst_n = 1'b0; i_fifo_1_full = 1'b0;
    #1;
    n_tests++;
    if ({o_data_read, o_fifo_1_write, o_fifo_2_write, o_done, o_err_zero, o_err_order} !== 6'b0 ||
        o_run_count !== '0 || o_fifo_1_data !== '0) begin
      n_fail++;
      $display("FAIL arst_outputs got rd=%b w1=%b w2=%b done=%b rc=%0d d=%0d required all 0",
               o_data_read, o_fifo_1_write, o_fifo_2_write, o_done, o_run_count, o_fifo_1_data);
    end
    @(negedge i_clk); i_rst_n = 1'b1; i_data_empty = 1'b0; i_data = DATA_W'(7);
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk); #1;
      if (o_fifo_1_write || o_fifo_2_write || o_data_read || o_done) acts++;
    end
    n_tests++; if (acts != 0) begin n_fail++; $display("FAIL arst_quiet got %0d active cycles required 0", acts); end
    i_data_empty = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_f1_stall();
    test_errors();
    test_random();
    test_async_reset();
    test_basic();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
